// File: rtl/fir_mc_tdm_if.sv
// Bus bundle for fir_mc_tdm: frame strobe, sample inputs, coefficient port and filtered output.
// The master modport drives the filter; the slave modport is the filter side.
interface fir_mc_tdm_if #(
    parameter int unsigned BITSIZE    = 16,
    parameter int unsigned LENGTH     = 21,
    parameter int unsigned CH         = 4,
    parameter int unsigned COEFF_BITS = 16
);
    localparam int unsigned AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

    logic                    EN;
    logic                    START_FLAG;
    logic [CH*BITSIZE-1:0]   DATA_IN;
    logic                    COEFF_WE;
    logic [AW-1:0]           COEFF_ADDR;
    logic [COEFF_BITS-1:0]   COEFF_DATA;
    logic [BITSIZE-1:0]      DATA_OUT;
    logic [CW-1:0]           DATA_CH;
    logic                    DATA_VALID;
    logic                    BUSY;
    logic                    OVERRUN;

    modport master (
        output EN, START_FLAG, DATA_IN, COEFF_WE, COEFF_ADDR, COEFF_DATA,
        input  DATA_OUT, DATA_CH, DATA_VALID, BUSY, OVERRUN
    );

    modport slave (
        input  EN, START_FLAG, DATA_IN, COEFF_WE, COEFF_ADDR, COEFF_DATA,
        output DATA_OUT, DATA_CH, DATA_VALID, BUSY, OVERRUN
    );
endinterface

// File: rtl/fir_mc_tdm.sv
// Multi-channel time-multiplexed FIR: one shared MAC walks CH channels per frame.
// Define FIR_MC_TDM_SATURATE_EN to clamp outputs instead of wrapping them.
module fir_mc_tdm #(
    parameter int unsigned BITSIZE    = 16,
    parameter int unsigned LENGTH     = 21,
    parameter int unsigned CH         = 4,
    parameter int unsigned COEFF_BITS = 16,
    parameter int unsigned COEFF_FRAC = 14
) (
    input logic           CLK,
    input logic           nRST,
    fir_mc_tdm_if.slave   bus
);
    localparam int unsigned AW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam int unsigned CW   = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned PW   = BITSIZE + COEFF_BITS;
    localparam int unsigned ACCW = PW + $clog2(LENGTH);

    localparam logic [AW-1:0]                 T_LAST = AW'(LENGTH - 1);
    localparam logic [CW-1:0]                 C_LAST = CW'(CH - 1);
    localparam logic [AW:0]                   LEN_W  = (AW + 1)'(LENGTH);
    localparam logic signed [COEFF_BITS-1:0]  H_ONE  = COEFF_BITS'(1) << COEFF_FRAC;
    localparam logic signed [ACCW-1:0]        RND    = ACCW'(1) << (COEFF_FRAC - 1);
    localparam logic signed [ACCW-1:0]        SAT_MAX =
        {{(ACCW - BITSIZE + 1){1'b0}}, {(BITSIZE - 1){1'b1}}};
    localparam logic signed [ACCW-1:0]        SAT_MIN =
        {{(ACCW - BITSIZE + 1){1'b1}}, {(BITSIZE - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                        state_q, state_d;
    logic                          start_flag_q, start_flag_d;
    logic [CW-1:0]                 c_q, c_d;
    logic [AW-1:0]                 t_q, t_d;
    logic signed [ACCW-1:0]        acc_q, acc_d;
    logic signed [BITSIZE-1:0]     x_q [CH][LENGTH];
    logic signed [BITSIZE-1:0]     x_d [CH][LENGTH];
    logic signed [COEFF_BITS-1:0]  h_q [LENGTH];
    logic signed [COEFF_BITS-1:0]  h_d [LENGTH];
    logic [BITSIZE-1:0]            data_out_q, data_out_d;
    logic [CW-1:0]                 data_ch_q, data_ch_d;
    logic                          valid_q, valid_d;
    logic                          busy_q, busy_d;
    logic                          overrun_q, overrun_d;

    logic                          start;
    logic signed [PW-1:0]          prod;
    logic signed [ACCW-1:0]        rnd;
    logic signed [ACCW-1:0]        y;
    logic [BITSIZE-1:0]            y_red;

    always_comb begin
        start_flag_d = bus.START_FLAG;
        start        = bus.START_FLAG & ~start_flag_q;
        prod         = x_q[c_q][t_q] * h_q[t_q];
        rnd          = acc_q + RND;
        y            = rnd >>> COEFF_FRAC;
`ifdef FIR_MC_TDM_SATURATE_EN
        if (y > SAT_MAX)      y_red = SAT_MAX[BITSIZE-1:0];
        else if (y < SAT_MIN) y_red = SAT_MIN[BITSIZE-1:0];
        else                  y_red = y[BITSIZE-1:0];
`else
        y_red = y[BITSIZE-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        t_d        = t_q;
        acc_d      = acc_q;
        x_d        = x_q;
        h_d        = h_q;
        data_out_d = data_out_q;
        data_ch_d  = data_ch_q;
        valid_d    = 1'b0;
        busy_d     = busy_q;
        overrun_d  = overrun_q;

        // A write in the same cycle as a start is visible to the first MAC cycle.
        if (bus.COEFF_WE && state_q == StIdle && {1'b0, bus.COEFF_ADDR} < LEN_W) begin
            h_d[bus.COEFF_ADDR] = bus.COEFF_DATA;
        end

        if (!bus.EN) begin
            state_d   = StIdle;
            busy_d    = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (start && state_q != StIdle) overrun_d = 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        for (int c = 0; c < int'(CH); c++) begin
                            for (int t = int'(LENGTH) - 1; t > 0; t--) x_d[c][t] = x_q[c][t-1];
                            x_d[c][0] = bus.DATA_IN[c*BITSIZE +: BITSIZE];
                        end
                        busy_d  = 1'b1;
                        c_d     = '0;
                        t_d     = '0;
                        state_d = StMac;
                    end
                end
                StMac: begin
                    acc_d = (t_q == '0) ? ACCW'(prod) : acc_q + ACCW'(prod);
                    if (t_q == T_LAST) begin
                        t_d     = '0;
                        state_d = StOut;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
                StOut: begin
                    data_out_d = y_red;
                    data_ch_d  = c_q;
                    valid_d    = 1'b1;
                    if (c_q == C_LAST) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        c_d     = c_q + 1'b1;
                        state_d = StMac;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StIdle;
            start_flag_q <= 1'b0;
            c_q          <= '0;
            t_q          <= '0;
            acc_q        <= '0;
            data_out_q   <= '0;
            data_ch_q    <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            for (int c = 0; c < int'(CH); c++) begin
                for (int t = 0; t < int'(LENGTH); t++) x_q[c][t] <= '0;
            end
            for (int t = 0; t < int'(LENGTH); t++) h_q[t] <= (t == 0) ? H_ONE : '0;
        end else begin
            state_q      <= state_d;
            start_flag_q <= start_flag_d;
            c_q          <= c_d;
            t_q          <= t_d;
            acc_q        <= acc_d;
            data_out_q   <= data_out_d;
            data_ch_q    <= data_ch_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            x_q          <= x_d;
            h_q          <= h_d;
        end
    end

    assign bus.DATA_OUT   = data_out_q;
    assign bus.DATA_CH    = data_ch_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.BUSY       = busy_q;
    assign bus.OVERRUN    = overrun_q;
endmodule

// File: tb/tb_fir_mc_tdm.sv
// Directed bench for fir_mc_tdm with a reference-model scoreboard on the output stream.
// Honours FIR_MC_TDM_SATURATE_EN for the overflow expectation.
module tb_fir_mc_tdm;
    localparam int BS    = 16;
    localparam int L     = 21;
    localparam int NC    = 4;
    localparam int CF    = 14;
    localparam int FRAME = L + 1;
`ifdef FIR_MC_TDM_SATURATE_EN
    localparam int OVF_EXP = 32767;
`else
    localparam int OVF_EXP = -2;
`endif

    typedef struct {
        int ch;
        int d;
        int at;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    int   ch0_log[$];
    int   xm[NC][L];
    int   hm[L];

    fir_mc_tdm_if #(.BITSIZE(BS), .LENGTH(L), .CH(NC), .COEFF_BITS(16)) bus ();

    fir_mc_tdm #(
        .BITSIZE(BS), .LENGTH(L), .CH(NC), .COEFF_BITS(16), .COEFF_FRAC(CF)
    ) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NC; c++) for (int t = 0; t < L; t++) xm[c][t] = 0;
        for (int t = 0; t < L; t++) hm[t] = 0;
        hm[0] = 1 << CF;
    endfunction

    function automatic int model_y(input int c);
        longint s = 0;
        longint y;
        for (int t = 0; t < L; t++) s += longint'(xm[c][t]) * longint'(hm[t]);
        y = (s + (longint'(1) <<< (CF - 1))) >>> CF;
`ifdef FIR_MC_TDM_SATURATE_EN
        if (y > 32767) y = 32767;
        else if (y < -32768) y = -32768;
        return int'(y);
`else
        return int'(shortint'(y));
`endif
    endfunction

    task automatic wr_coeff(input int a, input int d, input bit accepted);
        bus.COEFF_WE   = 1'b1;
        bus.COEFF_ADDR = 5'(a);
        bus.COEFF_DATA = 16'(d);
        if (accepted && a < L) hm[a] = d;
        step(1);
        bus.COEFF_WE = 1'b0;
    endtask

    task automatic start_frame(input int v0, input int v1, input int v2, input int v3,
                               input int nexp, output int k);
        int   v[NC];
        exp_t e;
        v = '{v0, v1, v2, v3};
        for (int c = 0; c < NC; c++) bus.DATA_IN[c*BS +: BS] = 16'(v[c]);
        bus.START_FLAG = 1'b1;
        k = cyc + 1;
        for (int c = 0; c < NC; c++) begin
            for (int t = L - 1; t > 0; t--) xm[c][t] = xm[c][t-1];
            xm[c][0] = v[c];
        end
        for (int c = 0; c < nexp; c++) begin
            e.ch = c;
            e.d  = model_y(c);
            e.at = k + (c + 1) * FRAME;
            q.push_back(e);
        end
        step(1);
        bus.START_FLAG = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((bus.BUSY !== 1'b0 || q.size() != 0) && n < NC * FRAME + 50) begin
            step(1);
            n++;
        end
        chk({tag, "_idle"}, bus.BUSY, 0);
        chk({tag, "_sb_empty"}, q.size(), 0);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        q.delete();
        ch0_log.delete();
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        int k;
        int ma_exp[5];
        exp_t e;
        ma_exp = '{250, 500, 750, 1000, 1000};
        rst_n          = 1'b0;
        bus.EN         = 1'b0;
        bus.START_FLAG = 1'b0;
        bus.DATA_IN    = '0;
        bus.COEFF_WE   = 1'b0;
        bus.COEFF_ADDR = '0;
        bus.COEFF_DATA = '0;
        model_reset();

        fork
            forever begin
                @(negedge clk);
                if (bus.DATA_VALID === 1'b1) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $error("FAIL unexpected_valid observed=1 expected=0 ch=%0d", bus.DATA_CH);
                    end else begin
                        e = q.pop_front();
                        chk("out_ch", bus.DATA_CH, e.ch);
                        chk("out_data", $signed(bus.DATA_OUT), e.d);
                        chk("out_latency", cyc, e.at);
                        if (e.ch == 0) ch0_log.push_back(int'($signed(bus.DATA_OUT)));
                    end
                end
            end
        join_none

        step(3);
        chk("rst_data_out", bus.DATA_OUT, 0);
        chk("rst_data_ch", bus.DATA_CH, 0);
        chk("rst_valid", bus.DATA_VALID, 0);
        chk("rst_busy", bus.BUSY, 0);
        chk("rst_overrun", bus.OVERRUN, 0);
        rst_n  = 1'b1;
        bus.EN = 1'b1;
        step(2);

        // Identity filter straight out of reset, with BUSY timing at the frame end.
        start_frame(100, -200, 32767, -32768, NC, k);
        chk("busy_running", bus.BUSY, 1);
        while (cyc < k + NC * FRAME - 1) step(1);
        chk("busy_last", bus.BUSY, 1);
        step(1);
        chk("busy_drop", bus.BUSY, 0);
        drain("identity");

        // Four-tap moving average on a step.
        rst_pulse();
        for (int t = 0; t < L; t++) wr_coeff(t, (t < 4) ? 4096 : 0, 1'b1);
        for (int f = 0; f < 5; f++) begin
            start_frame(1000, 0, 0, 0, NC, k);
            drain("mavg");
        end
        chk("mavg_count", ch0_log.size(), 5);
        for (int i = 0; i < 5; i++) chk("mavg_value", ch0_log[i], ma_exp[i]);

        // Output overflow: wrap or clamp.
        rst_pulse();
        for (int t = 0; t < L; t++) wr_coeff(t, 16384, 1'b1);
        for (int f = 0; f < 2; f++) begin
            start_frame(32767, 0, 0, 0, NC, k);
            drain("ovf");
        end
        chk("ovf_count", ch0_log.size(), 2);
        chk("ovf_first", ch0_log[0], 32767);
        chk("ovf_second", ch0_log[1], OVF_EXP);

        // Start while busy is dropped and flagged; EN low clears the flag.
        rst_pulse();
        start_frame(11, 22, 33, 44, NC, k);
        while (cyc < k + 9) step(1);
        chk("ovr_pre", bus.OVERRUN, 0);
        bus.START_FLAG = 1'b1;
        step(1);
        chk("ovr_set", bus.OVERRUN, 1);
        bus.START_FLAG = 1'b0;
        drain("ovr");
        chk("ovr_sticky", bus.OVERRUN, 1);
        bus.EN = 1'b0;
        step(1);
        bus.EN = 1'b1;
        chk("ovr_clear", bus.OVERRUN, 0);

        // Start coinciding with the final output cycle is also dropped.
        start_frame(5, 6, 7, 8, NC, k);
        while (cyc < k + NC * FRAME - 1) step(1);
        bus.START_FLAG = 1'b1;
        step(1);
        bus.START_FLAG = 1'b0;
        chk("ovr_final_out", bus.OVERRUN, 1);
        drain("final_out");
        bus.EN = 1'b0;
        step(1);
        bus.EN = 1'b1;

        // Coefficient writes while busy or out of range are ignored.
        start_frame(7, 8, 9, 10, NC, k);
        while (cyc < k + 4) step(1);
        wr_coeff(0, 0, 1'b0);
        drain("wr_busy");
        wr_coeff(21, 1234, 1'b0);
        start_frame(-1, 2, -3, 4, NC, k);
        drain("wr_range");

        // EN low mid-frame aborts after channel 0.
        start_frame(300, 400, 500, 600, 1, k);
        while (cyc < k + 29) step(1);
        bus.EN = 1'b0;
        step(2);
        chk("abort_busy", bus.BUSY, 0);
        bus.EN = 1'b1;
        step(NC * FRAME);
        chk("abort_sb_empty", q.size(), 0);

        // Asynchronous reset mid-frame restores identity coefficients.
        wr_coeff(0, 0, 1'b1);
        wr_coeff(1, 16384, 1'b1);
        start_frame(9, 9, 9, 9, 0, k);
        while (cyc < k + 15) step(1);
        rst_n = 1'b0;
        #1;
        chk("arst_data_out", bus.DATA_OUT, 0);
        chk("arst_busy", bus.BUSY, 0);
        chk("arst_valid", bus.DATA_VALID, 0);
        chk("arst_overrun", bus.OVERRUN, 0);
        model_reset();
        q.delete();
        step(1);
        rst_n = 1'b1;
        step(1);
        start_frame(1111, -2222, 3333, -4444, NC, k);
        drain("arst_identity");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
